// File: rtl/morse_pkg.sv
// Shared Morse definitions: 2-bit symbol codes and the capture FSM state encoding.
// The letter lookup logic uses the same codes.
package morse_pkg;

  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRESS = 3'd1,
    S_GAP   = 3'd2,
    S_PEND  = 3'd3,
    S_WORD  = 3'd4
  } state_e;

endpackage

// File: rtl/morse_key_debounce.sv
// Key conditioner: two-flop synchroniser followed by a stability filter that
// accepts a new level only after DEBOUNCE_CYCLES consecutive cycles at that level.
module morse_key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic key_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= 2'b00;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q <= {sync_q[0], key_i};
      // Any return to the accepted level restarts the stability count.
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign key_o = stable_q;

endmodule

// File: rtl/morse_keyer_decoder.sv
// Morse key capture: times presses and gaps, assembles letters and hands them out on valid/ready.
// Define MORSE_KEY_DEBOUNCE_EN to insert the synchroniser + debounce filter on the key input.
module morse_keyer_decoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES      = 4,
  parameter int unsigned MAX_SYMBOLS      = 5,
  parameter int unsigned DASH_UNITS       = 2,
  parameter int unsigned LETTER_GAP_UNITS = 3,
  parameter int unsigned WORD_GAP_UNITS   = 7,
`ifdef MORSE_KEY_DEBOUNCE_EN
  parameter int unsigned DEBOUNCE_CYCLES  = 8,
`endif
  localparam int unsigned LEN_W = $clog2(MAX_SYMBOLS + 1)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     key,
  output logic                     letter_valid,
  input  logic                     letter_ready,
  output logic [2*MAX_SYMBOLS-1:0] letter_symbols,
  output logic [LEN_W-1:0]         letter_len,
  output logic                     letter_overflow,
  output logic                     word_gap,
  output logic                     overrun,
  output logic                     key_state,
  output state_e                   dbg_state
);

  localparam int unsigned WGAP = WORD_GAP_UNITS * UNIT_CYCLES;
  localparam int unsigned CNT_W = $clog2(WGAP + 1);
  localparam logic [CNT_W-1:0] DOT_MIN_C  = CNT_W'(UNIT_CYCLES);
  localparam logic [CNT_W-1:0] DASH_MIN_C = CNT_W'(DASH_UNITS * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] LGAP_C     = CNT_W'(LETTER_GAP_UNITS * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] WGAP_C     = CNT_W'(WGAP);
  localparam logic [LEN_W-1:0] LEN_MAX_C  = LEN_W'(MAX_SYMBOLS);

  logic key_lvl;

`ifdef MORSE_KEY_DEBOUNCE_EN
  morse_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i (clock),
    .rst_ni(reset_n),
    .key_i (key),
    .key_o (key_lvl)
  );
`else
  logic key_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) key_q <= 1'b0;
    else          key_q <= key;
  end
  assign key_lvl = key_q;
`endif

  // Counters stop at the word-gap threshold, which is the largest value ever compared.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == WGAP_C) ? v : v + 1'b1;
  endfunction

  state_e                   state_q;
  logic [CNT_W-1:0]         press_cnt_q, gap_cnt_q, gap_inc;
  logic [2*MAX_SYMBOLS-1:0] buf_q, sym_out_q;
  logic [LEN_W-1:0]         len_q, len_out_q;
  logic                     ovf_q, ovf_out_q;
  logic                     valid_q, word_gap_q, overrun_q, key_prev_q;
  logic                     slot_free, emit;

  assign gap_inc   = sat_inc(gap_cnt_q);
  assign slot_free = !valid_q || letter_ready;
  assign emit      = slot_free &&
                     (((state_q == S_GAP) && !key_lvl && (gap_inc == LGAP_C)) ||
                      (state_q == S_PEND));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      press_cnt_q <= '0;
      gap_cnt_q   <= '0;
      buf_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      sym_out_q   <= '0;
      len_out_q   <= '0;
      ovf_out_q   <= 1'b0;
      valid_q     <= 1'b0;
      word_gap_q  <= 1'b0;
      overrun_q   <= 1'b0;
      key_prev_q  <= 1'b0;
    end else begin
      word_gap_q <= 1'b0;
      overrun_q  <= 1'b0;
      key_prev_q <= key_lvl;
      if (valid_q && letter_ready) valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (key_lvl) begin
            state_q     <= S_PRESS;
            press_cnt_q <= CNT_W'(1);
          end
        end
        S_PRESS: begin
          if (key_lvl) begin
            press_cnt_q <= sat_inc(press_cnt_q);
          end else if (press_cnt_q >= DOT_MIN_C) begin
            if (len_q == LEN_MAX_C) begin
              ovf_q <= 1'b1;
            end else begin
              buf_q[2*len_q +: 2] <= (press_cnt_q >= DASH_MIN_C) ? SYM_DASH : SYM_DOT;
              len_q <= len_q + 1'b1;
            end
            state_q   <= S_GAP;
            gap_cnt_q <= CNT_W'(1);
          end else if (len_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            state_q   <= S_GAP;
            gap_cnt_q <= CNT_W'(1);
          end
        end
        S_GAP: begin
          if (key_lvl) begin
            state_q     <= S_PRESS;
            press_cnt_q <= CNT_W'(1);
          end else begin
            gap_cnt_q <= gap_inc;
            if (gap_inc == LGAP_C) state_q <= slot_free ? S_WORD : S_PEND;
          end
        end
        S_PEND: begin
          // The buffered letter is waiting for the slot, so new presses are lost.
          gap_cnt_q <= gap_inc;
          if (key_lvl && !key_prev_q) overrun_q <= 1'b1;
          if (slot_free) state_q <= S_WORD;
        end
        S_WORD: begin
          if (key_lvl) begin
            state_q     <= S_PRESS;
            press_cnt_q <= CNT_W'(1);
          end else begin
            gap_cnt_q <= gap_inc;
            if (gap_inc == WGAP_C) begin
              word_gap_q <= 1'b1;
              state_q    <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (emit) begin
        sym_out_q <= buf_q;
        len_out_q <= len_q;
        ovf_out_q <= ovf_q;
        valid_q   <= 1'b1;
        buf_q     <= '0;
        len_q     <= '0;
        ovf_q     <= 1'b0;
      end
    end
  end

  assign letter_valid    = valid_q;
  assign letter_symbols  = sym_out_q;
  assign letter_len      = len_out_q;
  assign letter_overflow = ovf_out_q;
  assign word_gap        = word_gap_q;
  assign overrun         = overrun_q;
  assign key_state       = key_lvl;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_morse_keyer_decoder.sv
// Self-checking bench for morse_keyer_decoder (default build): directed key patterns,
// expected letters queued at stimulus time and popped by a monitor on each transfer.
module tb_morse_keyer_decoder;
  import morse_pkg::*;

  localparam int EW = 14;  // {overflow, len[2:0], symbols[9:0]}

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        key = 1'b0;
  logic        letter_ready = 1'b1;
  logic        letter_valid;
  logic [9:0]  letter_symbols;
  logic [2:0]  letter_len;
  logic        letter_overflow;
  logic        word_gap;
  logic        overrun;
  logic        key_state;
  state_e      dbg_state;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int wg_cnt = 0;
  int ov_cnt = 0;
  logic          stall_prev = 1'b0;
  logic [EW-1:0] held;

  morse_keyer_decoder dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .key            (key),
    .letter_valid   (letter_valid),
    .letter_ready   (letter_ready),
    .letter_symbols (letter_symbols),
    .letter_len     (letter_len),
    .letter_overflow(letter_overflow),
    .word_gap       (word_gap),
    .overrun        (overrun),
    .key_state      (key_state),
    .dbg_state      (dbg_state)
  );

  // Clock and reset
  always #5 clock = ~clock;

  // Monitor / scoreboard: samples on the falling edge, away from input changes.
  always @(negedge clock) begin
    if (!reset_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (word_gap) wg_cnt++;
      if (overrun)  ov_cnt++;
      if (stall_prev) begin
        checks++;
        if (!letter_valid || {letter_overflow, letter_len, letter_symbols} != held) begin
          failures++;
          $display("FAIL stall_hold: got valid=%0b data=%h, required valid=1 data=%h",
                   letter_valid, {letter_overflow, letter_len, letter_symbols}, held);
        end
      end
      stall_prev <= letter_valid && !letter_ready;
      held       <= {letter_overflow, letter_len, letter_symbols};
      if (letter_valid && letter_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL letter_unexpected: got data=%h, required no letter",
                   {letter_overflow, letter_len, letter_symbols});
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          if ({letter_overflow, letter_len, letter_symbols} != e) begin
            failures++;
            $display("FAIL letter_data: got ovf=%0b len=%0d sym=%h, required ovf=%0b len=%0d sym=%h",
                     letter_overflow, letter_len, letter_symbols, e[13], e[12:10], e[9:0]);
          end
        end
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input int n);
    key = 1'b1;
    idle(n);
    key = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic check_zero(input string name);
    check_int(name, int'({letter_valid, letter_symbols, letter_len, letter_overflow,
                          word_gap, overrun, key_state}), 0);
  endtask

  function automatic logic [EW-1:0] mk(input logic ovf, input logic [2:0] len,
                                       input logic [9:0] sym);
    return {ovf, len, sym};
  endfunction

  initial begin
    int n, lv_n, wg_n, wg_base;

    // Reset state
    #1;
    check_zero("reset_outputs");
    idle(3);
    reset_n = 1'b1;
    idle(2);
    check_zero("post_reset_idle");

    // Single dot 'E': letter 12 idle cycles after key_q falls, word gap at 28
    exp_q.push_back(mk(1'b0, 3'd1, 10'h001));
    press(4);
    lv_n = 0;
    wg_n = 0;
    n = 0;
    while (n < 60 && wg_n == 0) begin
      idle(1);
      n++;
      if (letter_valid && lv_n == 0) lv_n = n;
      if (word_gap && wg_n == 0) wg_n = n;
    end
    check_int("e_letter_latency", lv_n, 13);
    check_int("e_word_gap_latency", wg_n, 29);
    idle(5);
    check_int("e_word_gap_count", wg_cnt, 1);

    // Dot then dash 'A'
    exp_q.push_back(mk(1'b0, 3'd2, 10'h009));
    press(4);
    idle(4);
    press(8);
    idle(40);
    check_int("a_word_gap_count", wg_cnt, 2);

    // Glitch only: no letter, no word gap
    press(2);
    idle(40);
    check_int("glitch_no_valid", int'(letter_valid), 0);
    check_int("glitch_no_word_gap", wg_cnt, 2);

    // Six dots: five kept, overflow set
    exp_q.push_back(mk(1'b1, 3'd5, 10'h155));
    for (int i = 0; i < 6; i++) begin
      press(4);
      idle(4);
    end
    idle(40);
    check_int("ovf_word_gap_count", wg_cnt, 3);

    // Stalled consumer: first letter held, second pends, press during pend is lost
    letter_ready = 1'b0;
    exp_q.push_back(mk(1'b0, 3'd1, 10'h001));
    press(4);
    idle(20);
    check_int("stall_valid_held", int'(letter_valid), 1);
    exp_q.push_back(mk(1'b0, 3'd1, 10'h002));
    press(8);
    idle(16);
    check_int("pend_state", int'(dbg_state), int'(S_PEND));
    press(4);
    idle(4);
    check_int("overrun_count", ov_cnt, 1);
    letter_ready = 1'b1;
    idle(40);
    check_int("stall_queue_drained", exp_q.size(), 0);
    check_int("stall_word_gap_count", wg_cnt, 4);

    // Reset mid-press with two symbols buffered
    press(4);
    idle(4);
    press(4);
    idle(4);
    key = 1'b1;
    idle(3);
    reset_n = 1'b0;
    #1;
    check_zero("midpress_reset_outputs");
    key = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(2);
    wg_base = wg_cnt;
    exp_q.push_back(mk(1'b0, 3'd1, 10'h001));
    press(4);
    idle(40);
    check_int("after_reset_word_gap", wg_cnt - wg_base, 1);
    check_int("overrun_total", ov_cnt, 1);
    check_int("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
